// File: rtl/psola_sched_pkg.sv
// Shared types, widths and the tau clamp for the PSOLA scheduler.
// Used by psola_scheduler and, when PSOLA_SCHED_STATS_EN is defined, by its
// statistics counters.
package psola_sched_pkg;

  localparam int TAU_W  = 11;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_WAIT_YIN = 2'd1,
    ST_RUN      = 2'd2,
    ST_READY    = 2'd3
  } state_e;

  // Unsigned range limit applied to every YIN result before it reaches the wrapper
  function automatic logic [TAU_W-1:0] clamp_tau(input logic [TAU_W-1:0] tau,
                                                 input logic [TAU_W-1:0] lo,
                                                 input logic [TAU_W-1:0] hi);
    if (tau < lo) begin
      return lo;
    end else if (tau > hi) begin
      return hi;
    end
    return tau;
  endfunction

endpackage

// File: rtl/psola_scheduler_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Instantiated by psola_scheduler only when PSOLA_SCHED_STATS_EN is defined.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign count_d = (inc_in && (count_q != '1)) ? count_q + 1'b1 : count_q;

  // Count register with asynchronous clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/psola_scheduler.sv
// PSOLA scheduler: turns the sample strobe into window write addresses,
// launches YIN on each completed window, forwards a clamped (or fallback)
// tau and waits for the wrapper to finish before accepting the next window.
// Optional build macro PSOLA_SCHED_STATS_EN adds three saturating statistics
// outputs (windows_done_out, windows_dropped_out, timeouts_out).
module psola_scheduler
  import psola_sched_pkg::*;
#(
  parameter int  WINDOW_SIZE = 2048,
  parameter int  MIN_TAU     = 20,
  parameter int  MAX_TAU     = 2000,
  parameter int  DEFAULT_TAU = 400,
  parameter int  YIN_TIMEOUT = 65536,
  localparam int ADDR_W      = $clog2(WINDOW_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [15:0]       sample_in,
  input  logic              sample_strobe_in,
  output logic [15:0]       wr_sample_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic              wr_valid_out,
  output logic              yin_start_out,
  input  logic [TAU_W-1:0]  yin_tau_in,
  input  logic              yin_valid_in,
  output logic [TAU_W-1:0]  tau_out,
  output logic              tau_valid_out,
  input  logic              psola_done_in,
  output logic [1:0]        state_out,
  output logic              overrun_out,
  output logic              timeout_out
`ifdef PSOLA_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] windows_done_out,
  output logic [STAT_W-1:0] windows_dropped_out,
  output logic [STAT_W-1:0] timeouts_out
`endif
);

  localparam int TMR_W = $clog2(YIN_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(WINDOW_SIZE - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(YIN_TIMEOUT - 1);
  localparam logic [TAU_W-1:0]  TAU_LO      = TAU_W'(MIN_TAU);
  localparam logic [TAU_W-1:0]  TAU_HI      = TAU_W'(MAX_TAU);
  localparam logic [TAU_W-1:0]  TAU_DEFAULT = TAU_W'(DEFAULT_TAU);

  // Capture path
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [15:0]       wr_sample_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_valid_q;

  // Control path
  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             yin_start_q;
  logic [TAU_W-1:0] tau_q;
  logic             tau_valid_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             done_s_q;
  logic             done_d1_q;

  // Decoded events for the current cycle
  logic wb;
  logic done_rise;
  logic expired;
  logic ev_overrun;
  logic ev_timeout;
  logic ev_ready;

  assign cnt_d   = cnt_q + 1'b1;
  assign timer_d = timer_q + 1'b1;

  // A window boundary is the write of the last address becoming visible
  assign wb        = wr_valid_q && (wr_addr_q == LAST_ADDR);
  assign done_rise = done_s_q && !done_d1_q;
  assign expired   = (timer_q == TMR_LAST);

  // Any boundary in WAIT_YIN drops a window (re-launch or no launch at all);
  // in RUN it is dropped unless completion arrives in the same cycle.
  assign ev_overrun = wb && ((state_q == ST_WAIT_YIN) ||
                             ((state_q == ST_RUN) && !done_rise));
  assign ev_timeout = (state_q == ST_WAIT_YIN) && !yin_valid_in && expired;
  assign ev_ready   = (state_q == ST_RUN) && done_rise && !wb;

  // Sample capture: registered write to the wrapper, free-running address
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      wr_sample_q <= '0;
      wr_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
    end else begin
      wr_valid_q <= sample_strobe_in;
      if (sample_strobe_in) begin
        wr_sample_q <= sample_in;
        wr_addr_q   <= cnt_q;
        cnt_q       <= cnt_d;
      end
    end
  end

  // Completion edge detector: one register stage plus previous-value copy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      done_s_q  <= 1'b0;
      done_d1_q <= 1'b0;
    end else begin
      done_s_q  <= psola_done_in;
      done_d1_q <= done_s_q;
    end
  end

  // Scheduler FSM with registered pulses, tau and sticky flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_FILL;
      timer_q     <= '0;
      yin_start_q <= 1'b0;
      tau_q       <= '0;
      tau_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      yin_start_q <= 1'b0;
      tau_valid_q <= 1'b0;
      timer_q     <= timer_d;
      if (ev_overrun) begin
        overrun_q <= 1'b1;
      end
      if (ev_timeout) begin
        timeout_q <= 1'b1;
      end
      case (state_q)
        ST_FILL, ST_READY: begin
          if (wb) begin
            yin_start_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_WAIT_YIN;
          end
        end
        ST_WAIT_YIN: begin
          if (yin_valid_in) begin
            tau_q       <= clamp_tau(yin_tau_in, TAU_LO, TAU_HI);
            tau_valid_q <= 1'b1;
            state_q     <= ST_RUN;
          end else if (expired) begin
            tau_q       <= TAU_DEFAULT;
            tau_valid_q <= 1'b1;
            state_q     <= ST_RUN;
          end else if (wb) begin
            yin_start_q <= 1'b1;
            timer_q     <= '0;
          end
        end
        ST_RUN: begin
          if (done_rise) begin
            if (wb) begin
              yin_start_q <= 1'b1;
              timer_q     <= '0;
              state_q     <= ST_WAIT_YIN;
            end else begin
              state_q <= ST_READY;
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign wr_sample_out = wr_sample_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_valid_out  = wr_valid_q;
  assign yin_start_out = yin_start_q;
  assign tau_out       = tau_q;
  assign tau_valid_out = tau_valid_q;
  assign state_out     = state_q;
  assign overrun_out   = overrun_q;
  assign timeout_out   = timeout_q;

`ifdef PSOLA_SCHED_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_windows_done (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (ev_ready),
    .count_out (windows_done_out)
  );

  sat_counter #(.WIDTH(STAT_W)) u_windows_dropped (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (ev_overrun),
    .count_out (windows_dropped_out)
  );

  sat_counter #(.WIDTH(STAT_W)) u_timeouts (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (ev_timeout),
    .count_out (timeouts_out)
  );
`endif

endmodule
